// File: rtl/ram_seq_pkg.sv
// Shared definitions for the RAM sequencer: FSM encoding, tile geometry,
// address-width helper and the parameter legality checks.
package ram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STRB   = 3'd2,
    HOLD   = 3'd3,
    ERRACK = 3'd4
  } state_t;

  localparam int TILE_WORDS    = 16;
  localparam int TILE_BITS     = 4;
  localparam int MIN_WIDTH     = TILE_BITS;
  localparam int MIN_DEPTH     = TILE_WORDS;
  localparam int MIN_SETUP_CYC = 1;
  localparam int MIN_STRB_CYC  = 1;

  // An out-of-range request dwells this many cycles in ERRACK before its ACK.
  localparam int ERR_CYC = 2;

  // Word address width: enough bits for DEPTH, never fewer than one tile's 4.
  function automatic int calc_aw(input int depth);
    int aw;
    aw = $clog2(depth);
    return (aw < 4) ? 4 : aw;
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= MIN_WIDTH) && ((width % TILE_BITS) == 0);
  endfunction

  function automatic bit depth_ok(input int depth);
    return (depth >= MIN_DEPTH) && ((depth % TILE_WORDS) == 0);
  endfunction

  function automatic bit cycles_ok(input int setup_cyc, input int strb_cyc);
    return (setup_cyc >= MIN_SETUP_CYC) && (strb_cyc >= MIN_STRB_CYC);
  endfunction

endpackage

// File: rtl/RAM_16X4.sv
// Behavioural stand-in for the 16-word x 4-bit library RAM tile.
// Writes on the rising clock edge while selected with nWE low; drives its
// data pins only while selected with nOE low.
module RAM_16X4 (
  input  logic       CLK,
  input  logic [3:0] A,
  inout  wire  [3:0] D,
  input  logic       nCS,
  input  logic       nWE,
  input  logic       nOE
);

  logic [3:0] mem [16];

  // Store the bus value into the addressed nibble during a selected write strobe.
  always_ff @(posedge CLK) begin
    if (!nCS && !nWE) begin
      mem[A] <= D;
    end
  end

  assign D = (!nCS && !nOE) ? mem[A] : 4'bz;

endmodule

// File: rtl/ram_tile_array.sv
// DEPTH/16 rows x WIDTH/4 columns of RAM_16X4 tiles. The upper address bits
// pick one row through a NOT/NOR decoder; every tile shares addr[3:0] and
// the strobes, and each column owns one nibble of the shared data bus.
module ram_tile_array
  import ram_seq_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 64,
  localparam int AW    = calc_aw(DEPTH)
) (
  input  logic             CLK,
  input  logic [AW-1:0]    addr,
  input  logic             cs_n,
  input  logic             we_n,
  input  logic             oe_n,
  inout  wire  [WIDTH-1:0] data
);

  localparam int ROWS = DEPTH / TILE_WORDS;
  localparam int COLS = WIDTH / TILE_BITS;
  localparam int RW   = AW - 4;

  wire [ROWS-1:0] row_cs_n;

  generate
    if (ROWS == 1) begin : g_single_row
      assign row_cs_n[0] = cs_n;
    end else begin : g_decode
      wire [RW-1:0] addr_n;

      for (genvar b = 0; b < RW; b++) begin : g_inv
        not u_inv (addr_n[b], addr[4+b]);
      end

      // A row is selected only when no row-address bit misses and cs_n is low.
      for (genvar r = 0; r < ROWS; r++) begin : g_row
        wire [RW-1:0] miss;
        wire          row_sel;
        for (genvar b = 0; b < RW; b++) begin : g_bit
          if (((r >> b) & 1) == 1) begin : g_one
            assign miss[b] = addr_n[b];
          end else begin : g_zero
            assign miss[b] = addr[4+b];
          end
        end
        nor u_sel (row_sel, cs_n, |miss);
        not u_csn (row_cs_n[r], row_sel);
      end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_tile_row
      for (genvar c = 0; c < COLS; c++) begin : g_tile_col
        RAM_16X4 u_tile (
          .CLK (CLK),
          .A   (addr[3:0]),
          .D   (data[TILE_BITS*c +: TILE_BITS]),
          .nCS (row_cs_n[r]),
          .nWE (we_n),
          .nOE (oe_n)
        );
      end
    end
  endgenerate

endmodule

// File: rtl/ram_seq_ctrl.sv
// Sequencer for an asynchronous-style tile RAM: captures a request, walks
// the chip-select / strobe / hold phases, and returns a one-cycle ACK.
// Out-of-range addresses never touch the array and are answered with ERR.
module ram_seq_ctrl
  import ram_seq_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int DEPTH     = 64,
  parameter  int SETUP_CYC = 1,
  parameter  int STRB_CYC  = 2,
  localparam int AW        = calc_aw(DEPTH)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             REQ,
  input  logic             WR,
  input  logic [AW-1:0]    A,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] RD,
  output logic             ACK,
  output logic             ERR,
  output logic             BUSY
);

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("ram_seq_ctrl: WIDTH=%0d must be a multiple of 4 and at least 4", WIDTH);
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("ram_seq_ctrl: DEPTH=%0d must be a multiple of 16 and at least 16", DEPTH);
    end
    if (!cycles_ok(SETUP_CYC, STRB_CYC)) begin : g_bad_cycles
      $error("ram_seq_ctrl: SETUP_CYC=%0d and STRB_CYC=%0d must both be 1 or more",
             SETUP_CYC, STRB_CYC);
    end
  endgenerate

  localparam logic [AW:0] DEPTH_LIM  = (AW+1)'(DEPTH);
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] STRB_LAST  = 16'(STRB_CYC - 1);
  localparam logic [15:0] ERR_LAST   = 16'(ERR_CYC - 1);

  state_t           state;
  logic [15:0]      cnt;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic             is_wr;
  logic             cs_n;
  logic             we_n;
  logic             oe_n;
  logic             bus_drive;
  logic             in_range;

  wire  [WIDTH-1:0] bus;

  assign in_range = ({1'b0, A} < DEPTH_LIM);
  assign bus      = bus_drive ? wdata : {WIDTH{1'bz}};

  // Single FSM owning every control output so strobes and flags are glitch-free registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      cnt       <= '0;
      addr      <= '0;
      wdata     <= '0;
      is_wr     <= 1'b0;
      cs_n      <= 1'b1;
      we_n      <= 1'b1;
      oe_n      <= 1'b1;
      bus_drive <= 1'b0;
      RD        <= '0;
      ACK       <= 1'b0;
      ERR       <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      ACK <= 1'b0;
      ERR <= 1'b0;
      unique case (state)
        IDLE: begin
          if (REQ) begin
            addr  <= A;
            wdata <= WD;
            is_wr <= WR;
            cnt   <= '0;
            BUSY  <= 1'b1;
            if (in_range) begin
              state     <= SETUP;
              cs_n      <= 1'b0;
              bus_drive <= WR;
            end else begin
              state <= ERRACK;
            end
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state <= STRB;
            cnt   <= '0;
            we_n  <= !is_wr;
            oe_n  <= is_wr;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STRB: begin
          if (cnt == STRB_LAST) begin
            state <= HOLD;
            cnt   <= '0;
            we_n  <= 1'b1;
            oe_n  <= 1'b1;
            if (!is_wr) begin
              RD <= bus;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        HOLD: begin
          state     <= IDLE;
          cs_n      <= 1'b1;
          bus_drive <= 1'b0;
          ACK       <= 1'b1;
          BUSY      <= 1'b0;
        end
        ERRACK: begin
          if (cnt == ERR_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            ACK   <= 1'b1;
            ERR   <= 1'b1;
            BUSY  <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  ram_tile_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tiles (
    .CLK  (CLK),
    .addr (addr),
    .cs_n (cs_n),
    .we_n (we_n),
    .oe_n (oe_n),
    .data (bus)
  );

endmodule

// File: tb/tb_ram_seq_ctrl.sv
// Directed self-checking bench for ram_seq_ctrl: a default instance and a
// DEPTH=48 instance for the out-of-range path.
module tb_ram_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req = 1'b0;
  logic        req48 = 1'b0;
  logic        wr = 1'b0;
  logic [5:0]  a = '0;
  logic [15:0] wd = '0;

  logic [15:0] rd, rd48;
  logic        ack, err, busy;
  logic        ack48, err48, busy48;

  int checks = 0;
  int fails = 0;
  int cs48_cnt = 0;

  ram_seq_ctrl dut (
    .CLK(clk), .nRST(rst_n), .REQ(req), .WR(wr), .A(a), .WD(wd),
    .RD(rd), .ACK(ack), .ERR(err), .BUSY(busy)
  );

  ram_seq_ctrl #(.DEPTH(48)) dut48 (
    .CLK(clk), .nRST(rst_n), .REQ(req48), .WR(wr), .A(a), .WD(wd),
    .RD(rd48), .ACK(ack48), .ERR(err48), .BUSY(busy48)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Count cycles in which the DEPTH=48 instance has its chip select low.
  always @(negedge clk) begin
    if (dut48.cs_n === 1'b0) cs48_cnt <= cs48_cnt + 1;
  end

  // Issue one request, then count edges from acceptance to ACK (-1 on timeout).
  task automatic run_txn(input bit sel48, input bit wr_i, input logic [5:0] a_i,
                         input logic [15:0] wd_i, output int lat, output logic err_o);
    @(negedge clk);
    wr = wr_i; a = a_i; wd = wd_i;
    if (sel48) req48 = 1'b1; else req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; req48 = 1'b0;
    lat = -1; err_o = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if ((sel48 ? ack48 : ack) === 1'b1) begin
        lat = i;
        err_o = sel48 ? err48 : err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rd !== 16'h0000) begin fails++; $display("[TB] FAIL reset_rd: got %h, expected 0000", rd); end
    checks++; if (ack !== 1'b0) begin fails++; $display("[TB] FAIL reset_ack: got %b, expected 0", ack); end
    checks++; if (err !== 1'b0) begin fails++; $display("[TB] FAIL reset_err: got %b, expected 0", err); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy); end
    checks++; if ({dut.cs_n, dut.we_n, dut.oe_n} !== 3'b111) begin
      fails++; $display("[TB] FAIL reset_strobes: got %b, expected 111", {dut.cs_n, dut.we_n, dut.oe_n});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    int lat; logic e;
    run_txn(0, 1'b1, 6'd10, 16'h0C45, lat, e);
    checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL wr_latency: got %0d, expected 4", lat); end
    checks++; if (e !== 1'b0) begin fails++; $display("[TB] FAIL wr_err: got %b, expected 0", e); end
    run_txn(0, 1'b0, 6'd10, 16'h0000, lat, e);
    checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL rd_latency: got %0d, expected 4", lat); end
    checks++; if (rd !== 16'h0C45) begin fails++; $display("[TB] FAIL rd_data: got %h, expected 0c45", rd); end
    checks++; if (e !== 1'b0) begin fails++; $display("[TB] FAIL rd_err: got %b, expected 0", e); end
  endtask

  task automatic test_fill();
    int lat; logic e; logic [15:0] exp_d;
    for (int i = 0; i < 64; i++) begin
      exp_d = 16'((i * 32'h0101) ^ 32'hA5A5);
      run_txn(0, 1'b1, 6'(i), exp_d, lat, e);
    end
    for (int i = 0; i < 64; i++) begin
      exp_d = 16'((i * 32'h0101) ^ 32'hA5A5);
      run_txn(0, 1'b0, 6'(i), 16'h0000, lat, e);
      checks++;
      if (rd !== exp_d || lat !== 4) begin
        fails++; $display("[TB] FAIL fill_word %0d: got %h lat %0d, expected %h lat 4", i, rd, lat, exp_d);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic e;
    @(negedge clk);
    wr = 1'b1; a = 6'd1; wd = 16'h5A3C; req = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    wr = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin lat = i; break; end
    end
    checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL b2b_wr_latency: got %0d, expected 4", lat); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL b2b_busy_in_ack: got %b, expected 0", busy); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL b2b_accept: got busy %b, expected 1", busy); end
    req = 1'b0;
    lat = -1; e = 1'bx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin lat = i; e = err; break; end
    end
    checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL b2b_rd_latency: got %0d, expected 4", lat); end
    checks++; if (rd !== 16'h5A3C) begin fails++; $display("[TB] FAIL b2b_rd_data: got %h, expected 5a3c", rd); end
    checks++; if (e !== 1'b0) begin fails++; $display("[TB] FAIL b2b_rd_err: got %b, expected 0", e); end
  endtask

  task automatic test_ignore_busy_req();
    int lat; int acks; logic e;
    @(negedge clk);
    wr = 1'b1; a = 6'd21; wd = 16'h2222; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    acks = 0;
    @(negedge clk);
    wr = 1'b1; a = 6'd22; wd = 16'h3333; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    checks++; if (acks !== 1) begin fails++; $display("[TB] FAIL ignore_ack_count: got %0d, expected 1", acks); end
    run_txn(0, 1'b0, 6'd21, 16'h0000, lat, e);
    checks++; if (rd !== 16'h2222) begin fails++; $display("[TB] FAIL ignore_first_write: got %h, expected 2222", rd); end
    run_txn(0, 1'b0, 6'd22, 16'h0000, lat, e);
    checks++; if (rd !== 16'hB3B3) begin fails++; $display("[TB] FAIL ignore_no_second_write: got %h, expected b3b3", rd); end
  endtask

  task automatic test_out_of_range();
    int lat; int cs_before; logic e;
    run_txn(1, 1'b1, 6'd47, 16'h1234, lat, e);
    checks++; if (lat !== 4) begin fails++; $display("[TB] FAIL oor_wr47_latency: got %0d, expected 4", lat); end
    run_txn(1, 1'b0, 6'd47, 16'h0000, lat, e);
    checks++; if (rd48 !== 16'h1234) begin fails++; $display("[TB] FAIL oor_rd47_data: got %h, expected 1234", rd48); end
    cs_before = cs48_cnt;
    run_txn(1, 1'b0, 6'd50, 16'h0000, lat, e);
    checks++; if (lat !== 2) begin fails++; $display("[TB] FAIL oor_latency: got %0d, expected 2", lat); end
    checks++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL oor_err: got %b, expected 1", e); end
    checks++; if (rd48 !== 16'h1234) begin fails++; $display("[TB] FAIL oor_rd_kept: got %h, expected 1234", rd48); end
    checks++; if (cs48_cnt !== cs_before) begin
      fails++; $display("[TB] FAIL oor_no_cs: got %0d select cycles, expected 0", cs48_cnt - cs_before);
    end
    run_txn(1, 1'b0, 6'd47, 16'h0000, lat, e);
    checks++; if (e !== 1'b0 || lat !== 4) begin
      fails++; $display("[TB] FAIL oor_rd47_after: got err %b lat %0d, expected err 0 lat 4", e, lat);
    end
  endtask

  task automatic test_reset_mid_write();
    int lat; int acks; logic e;
    @(negedge clk);
    wr = 1'b1; a = 6'd5; wd = 16'h7777; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #2;
    checks++; if (dut.we_n !== 1'b0) begin fails++; $display("[TB] FAIL mid_we_active: got %b, expected 0", dut.we_n); end
    rst_n = 1'b0;
    #1;
    checks++; if ({dut.cs_n, dut.we_n, dut.oe_n} !== 3'b111) begin
      fails++; $display("[TB] FAIL mid_strobes: got %b, expected 111", {dut.cs_n, dut.we_n, dut.oe_n});
    end
    checks++; if (dut.bus_drive !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("[TB] FAIL mid_idle: got drive %b busy %b, expected 0 0", dut.bus_drive, busy);
    end
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
    end
    @(negedge clk);
    rst_n = 1'b1; wr = 1'b0; a = 6'd4; req = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL first_edge_accept: got busy %b, expected 1", busy); end
    req = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) begin lat = i; break; end
    end
    checks++; if (acks !== 0 || lat !== 4) begin
      fails++; $display("[TB] FAIL mid_no_ack: got %0d acks lat %0d, expected 0 acks lat 4", acks, lat);
    end
    checks++; if (rd !== 16'hA1A1) begin fails++; $display("[TB] FAIL mid_keep_a4: got %h, expected a1a1", rd); end
    run_txn(0, 1'b0, 6'd6, 16'h0000, lat, e);
    checks++; if (rd !== 16'hA3A3) begin fails++; $display("[TB] FAIL mid_keep_a6: got %h, expected a3a3", rd); end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    test_reset();
    test_write_read();
    test_fill();
    test_back_to_back();
    test_ignore_busy_req();
    test_out_of_range();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
